// File: rtl/gate_func_identifier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_func_pkg
// Description : Shared types, truth-table constants and the truth->code decoder
//               for the mux function identifier.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_func_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECODE = 2'd2
    } state_t;

    typedef logic [3:0] truth_t;
    typedef logic [2:0] code_t;

    // Truth tables indexed by {a,b}: bit i = f(a=i[1], b=i[0])
    localparam truth_t TT_NOT  = 4'b0011;
    localparam truth_t TT_BUF  = 4'b1100;
    localparam truth_t TT_XNOR = 4'b1001;
    localparam truth_t TT_XOR  = 4'b0110;
    localparam truth_t TT_OR   = 4'b1110;
    localparam truth_t TT_NOR  = 4'b0001;
    localparam truth_t TT_AND  = 4'b1000;
    localparam truth_t TT_NAND = 4'b0111;

    localparam code_t CODE_NOT  = 3'd0;
    localparam code_t CODE_BUF  = 3'd1;
    localparam code_t CODE_XNOR = 3'd2;
    localparam code_t CODE_XOR  = 3'd3;
    localparam code_t CODE_OR   = 3'd4;
    localparam code_t CODE_NOR  = 3'd5;
    localparam code_t CODE_AND  = 3'd6;
    localparam code_t CODE_NAND = 3'd7;

    // Returns {valid, code}
    function automatic logic [3:0] decode_truth(input truth_t truth);
        case (truth)
            TT_NOT:  return {1'b1, CODE_NOT};
            TT_BUF:  return {1'b1, CODE_BUF};
            TT_XNOR: return {1'b1, CODE_XNOR};
            TT_XOR:  return {1'b1, CODE_XOR};
            TT_OR:   return {1'b1, CODE_OR};
            TT_NOR:  return {1'b1, CODE_NOR};
            TT_AND:  return {1'b1, CODE_AND};
            TT_NAND: return {1'b1, CODE_NAND};
            default: return 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_func_identifier_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_func_identifier_if
// Description : Probe, handshake and result signals of the function identifier.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_func_identifier_if;
    import gate_func_pkg::*;

    logic   start;
    logic   dut_out;
    logic   probe_a;
    logic   probe_b;
    logic   busy;
    logic   done;
    truth_t truth;
    code_t  code;
    logic   valid;

    modport master (
        output start, dut_out,
        input  probe_a, probe_b, busy, done, truth, code, valid
    );

    modport slave (
        input  start, dut_out,
        output probe_a, probe_b, busy, done, truth, code, valid
    );

endinterface
`default_nettype wire

// File: rtl/gate_func_identifier_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : N-flop single-bit synchronizer; STAGES = 0 is a plain wire.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int STAGES = 2
) (
    input  wire  clk,
    input  wire  rst_n,
    input  wire  d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [STAGES-1:0] r_chain;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_chain <= '0;
                end else begin
                    r_chain[0] <= d;
                    for (int k = 1; k < STAGES; k++) begin
                        r_chain[k] <= r_chain[k-1];
                    end
                end
            end

            assign q = r_chain[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/gate_func_identifier.sv
`default_nettype none
// ============================================================================
// Module      : gate_func_identifier
// Description : Walks a two-input function mux through all four input vectors,
//               captures its truth table and decodes the select code.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_func_identifier
    import gate_func_pkg::*;
#(
    parameter int SETTLE_CYCLES = 3,
    parameter int SYNC_STAGES   = 2
) (
    input wire                   clk,
    input wire                   rst_n,
    gate_func_identifier_if.slave bus
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_param_check
            $error("SETTLE_CYCLES must be >= SYNC_STAGES+1");
        end
    endgenerate

    state_t           r_state,  w_state;
    logic [1:0]       r_index,  w_index;
    logic [CNT_W-1:0] r_cnt,    w_cnt;
    logic [1:0]       r_probe,  w_probe;
    truth_t           r_shadow, w_shadow;
    logic             r_busy,   w_busy;
    logic             r_done,   w_done;
    truth_t           r_truth,  w_truth;
    code_t            r_code,   w_code;
    logic             r_valid,  w_valid;
    logic             w_sync;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.dut_out),
        .q     (w_sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_index  <= '0;
            r_cnt    <= '0;
            r_probe  <= '0;
            r_shadow <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_truth  <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_index  <= w_index;
            r_cnt    <= w_cnt;
            r_probe  <= w_probe;
            r_shadow <= w_shadow;
            r_busy   <= w_busy;
            r_done   <= w_done;
            r_truth  <= w_truth;
            r_code   <= w_code;
            r_valid  <= w_valid;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_index  = r_index;
        w_cnt    = r_cnt;
        w_probe  = r_probe;
        w_shadow = r_shadow;
        w_busy   = r_busy;
        w_done   = 1'b0;
        w_truth  = r_truth;
        w_code   = r_code;
        w_valid  = r_valid;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state  = SETTLE;
                    w_busy   = 1'b1;
                    w_truth  = '0;
                    w_code   = '0;
                    w_valid  = 1'b0;
                    w_shadow = '0;
                    w_index  = '0;
                    w_probe  = '0;
                    w_cnt    = '0;
                end
            end
            SETTLE: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_cnt             = '0;
                    w_shadow[r_index] = w_sync;
                    if (r_index == 2'd3) begin
                        w_state = DECODE;
                        w_probe = '0;
                    end else begin
                        w_index = r_index + 2'd1;
                        w_probe = r_index + 2'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            DECODE: begin
                w_truth           = r_shadow;
                {w_valid, w_code} = decode_truth(r_shadow);
                w_done            = 1'b1;
                w_busy            = 1'b0;
                w_state           = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.probe_a = r_probe[1];
    assign bus.probe_b = r_probe[0];
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.truth   = r_truth;
    assign bus.code    = r_code;
    assign bus.valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_func_identifier.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_func_identifier
// Description : Scoreboard bench driving two identifiers (default and fast
//               parameter sets) against a behavioural model of the function mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_func_identifier;
    import gate_func_pkg::*;

    localparam int S0 = 3;
    localparam int Y0 = 2;
    localparam int S1 = 1;
    localparam int Y1 = 0;

    localparam int M_MUX  = 0;
    localparam int M_TIE0 = 1;
    localparam int M_TIE1 = 2;

    typedef struct {
        logic [3:0] truth;
        logic [2:0] code;
        logic       valid;
        int         done_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    int         mode0 = M_MUX, mode1 = M_MUX;
    logic [2:0] sel0 = '0, sel1 = '0;
    int         e0_0 = -1000, e0_1 = -1000;
    exp_t       q0[$];
    exp_t       q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_func_identifier_if bus0 ();
    gate_func_identifier_if bus1 ();

    gate_func_identifier #(.SETTLE_CYCLES(S0), .SYNC_STAGES(Y0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
    );
    gate_func_identifier #(.SETTLE_CYCLES(S1), .SYNC_STAGES(Y1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );

    // Behavioural model of the mux under test, or a tied-off output
    function automatic logic ref_f(input int mode, input logic [2:0] sel, input logic a, input logic b);
        if (mode == M_TIE0) return 1'b0;
        if (mode == M_TIE1) return 1'b1;
        case (sel)
            3'd0:    return !a;
            3'd1:    return a;
            3'd2:    return !(a ^ b);
            3'd3:    return a ^ b;
            3'd4:    return a | b;
            3'd5:    return !(a | b);
            3'd6:    return a & b;
            default: return !(a & b);
        endcase
    endfunction

    assign bus0.dut_out = ref_f(mode0, sel0, bus0.probe_a, bus0.probe_b);
    assign bus1.dut_out = ref_f(mode1, sel1, bus1.probe_a, bus1.probe_b);

    function automatic exp_t make_exp(input int mode, input logic [2:0] sel, input int done_edge);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = i[1:0];
            e.truth[i] = ref_f(mode, sel, ab[1], ab[0]);
        end
        e.valid     = (mode == M_MUX);
        e.code      = e.valid ? sel : 3'd0;
        e.done_edge = done_edge;
        return e;
    endfunction

    function automatic logic [1:0] exp_probe(input int d, input int s);
        return (d < 4 * s) ? 2'(d / s) : 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_done(input string tag, input exp_t e, input logic [3:0] truth,
                                input logic [2:0] code, input logic valid);
        check({tag, "_truth"}, 32'(truth), 32'(e.truth));
        check({tag, "_code"},  32'(code),  32'(e.code));
        check({tag, "_valid"}, 32'(valid), 32'(e.valid));
        check({tag, "_latency"}, 32'(cyc), 32'(e.done_edge));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus0.busy)
            check("probe0", 32'({bus0.probe_a, bus0.probe_b}), 32'(exp_probe(cyc - e0_0, S0)));
        if (rst_n && bus0.done) begin
            if (q0.size() == 0) check("done0_unexpected", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                monitor_done("run0", e, bus0.truth, bus0.code, bus0.valid);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus1.busy)
            check("probe1", 32'({bus1.probe_a, bus1.probe_b}), 32'(exp_probe(cyc - e0_1, S1)));
        if (rst_n && bus1.done) begin
            if (q1.size() == 0) check("done1_unexpected", 32'd1, 32'd0);
            else begin
                e = q1.pop_front();
                monitor_done("run1", e, bus1.truth, bus1.code, bus1.valid);
            end
        end
    end

    // Called at a negedge while the identifier is idle (or in its done cycle)
    task automatic issue0(input int mode, input logic [2:0] sel);
        mode0 = mode;
        sel0  = sel;
        q0.push_back(make_exp(mode, sel, cyc + 1 + 4 * S0 + 1));
        e0_0 = cyc + 1;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    task automatic issue1(input int mode, input logic [2:0] sel);
        mode1 = mode;
        sel1  = sel;
        q1.push_back(make_exp(mode, sel, cyc + 1 + 4 * S1 + 1));
        e0_1 = cyc + 1;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
    endtask

    task automatic wait_done0();
        int n = 0;
        while (!bus0.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus0.done) check("done0_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done1();
        int n = 0;
        while (!bus1.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus1.done) check("done1_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] outs0();
        return 32'({bus0.probe_a, bus0.probe_b, bus0.busy, bus0.done, bus0.truth, bus0.code, bus0.valid});
    endfunction

    function automatic logic [31:0] outs1();
        return 32'({bus1.probe_a, bus1.probe_b, bus1.busy, bus1.done, bus1.truth, bus1.code, bus1.valid});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        #12;
        check("reset_outs0", outs0(), 32'd0);
        check("reset_outs1", outs1(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single XOR run with latency check
        issue0(M_MUX, 3'd3);
        wait_done0();
        @(negedge clk);

        // Back-to-back sweep of every select, random starting point
        begin
            logic [2:0] base;
            base = 3'($urandom_range(0, 7));
            issue0(M_MUX, base);
            for (int s = 1; s < 8; s++) begin
                wait_done0();
                issue0(M_MUX, base + 3'(s));
            end
            wait_done0();
            @(negedge clk);
        end

        // Tied outputs produce invalid tables
        issue0(M_TIE0, 3'd0);
        wait_done0();
        @(negedge clk);
        issue0(M_TIE1, 3'd0);
        wait_done0();
        repeat (5) @(negedge clk);
        check("hold_truth", 32'(bus0.truth), 32'hF);
        check("hold_valid", 32'(bus0.valid), 32'd0);

        // Starts during vector 1 and during DECODE are ignored
        issue0(M_MUX, 3'd4);
        while (cyc < e0_0 + 3) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        while (cyc < e0_0 + 12) @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (20) @(negedge clk);
        check("ignored_busy", 32'(bus0.busy), 32'd0);
        check("ignored_truth", 32'(bus0.truth), 32'(TT_OR));

        // Reset mid-run during vector 2
        issue0(M_MUX, 3'd6);
        while (cyc < e0_0 + 7) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outs0", outs0(), 32'd0);
        q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue0(M_MUX, 3'd6);
        wait_done0();
        @(negedge clk);

        // Fast parameter set: no synchronizer, one cycle per vector
        issue1(M_MUX, 3'd6);
        wait_done1();
        @(negedge clk);
        issue1(M_MUX, 3'($urandom_range(0, 7)));
        wait_done1();
        issue1(M_TIE1, 3'd0);
        wait_done1();
        @(negedge clk);

        repeat (10) @(negedge clk);
        check("queue0_empty", 32'(q0.size()), 32'd0);
        check("queue1_empty", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
